// File: rtl/sv_param_arbiter.sv
// Registered N-way arbiter, fixed-priority or round-robin, grant locked while the owner requests.
// Latency 1 cycle req->grant; optional per-owner hold limit when ARB_HOLD_LIMIT_EN is defined.
module sv_param_arbiter #(
   parameter  int N        = 8,
   parameter  int HOLD_MAX = 4,
   localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode_rr,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt_onehot,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   typedef enum logic {IDLE, GRANT} state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   state_t           state_q, state_d;
   logic [N-1:0]     onehot_q, onehot_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;

   logic [N-1:0]     cand;
   logic [N-1:0]     others;
   logic             owner_req;
   logic             do_arb;
   pick_t            pk;

`ifdef ARB_HOLD_LIMIT_EN
   localparam int               CNT_W    = $clog2(HOLD_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

   // Fixed: highest set index wins. RR: later search positions are overwritten
   // by earlier ones, so the first set bit after ptr survives.
   function automatic pick_t pick(input logic [N-1:0] c, input logic rr,
                                  input logic [IDX_W-1:0] ptr);
      pick_t r;
      int    j;
      r = '0;
      if (!rr) begin
         for (int i = 0; i < N; i++) begin
            if (c[i]) begin
               r.found = 1'b1;
               r.idx   = IDX_W'(i);
            end
         end
      end else begin
         for (int k = N; k >= 1; k--) begin
            j = (int'(ptr) + k) % N;
            if (c[j]) begin
               r.found = 1'b1;
               r.idx   = IDX_W'(j);
            end
         end
      end
      return r;
   endfunction

   assign owner_req = |(req & onehot_q);
   assign others    = req & ~onehot_q;

   always_comb begin
      state_d  = state_q;
      onehot_d = onehot_q;
      idx_d    = idx_q;
      valid_d  = valid_q;
      ptr_d    = ptr_q;
      cand     = '0;
      do_arb   = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_d = hold_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (|req) begin
               do_arb = 1'b1;
               cand   = req;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               do_arb = 1'b1;
               cand   = others;
            end
`ifdef ARB_HOLD_LIMIT_EN
            else if (hold_cnt_q == HOLD_LIM && |others) begin
               do_arb = 1'b1;
               cand   = others;
            end else if (hold_cnt_q != HOLD_LIM) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase

      pk = pick(cand, mode_rr, ptr_q);

      if (do_arb) begin
         if (pk.found) begin
            state_d          = GRANT;
            onehot_d         = '0;
            onehot_d[pk.idx] = 1'b1;
            idx_d            = pk.idx;
            valid_d          = 1'b1;
            ptr_d            = pk.idx;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_d       = CNT_W'(1);
`endif
         end else begin
            state_d  = IDLE;
            onehot_d = '0;
            idx_d    = '0;
            valid_d  = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt_d = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         onehot_q <= '0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         ptr_q    <= IDX_W'(N - 1);
`ifdef ARB_HOLD_LIMIT_EN
         hold_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         onehot_q <= onehot_d;
         idx_q    <= idx_d;
         valid_q  <= valid_d;
         ptr_q    <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
         hold_cnt_q <= hold_cnt_d;
`endif
      end
   end

   assign gnt_onehot = onehot_q;
   assign gnt_idx    = idx_q;
   assign gnt_valid  = valid_q;

endmodule
